// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, FSM states and
// data-path select/ALU encodings.
package bip_pkg;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LATCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEMRD = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/bip_decoder.sv
// Opcode classifier for the BIP control unit; every opcode outside the
// defined set decodes as a NOP (all flags low).
module bip_decoder
  import bip_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_mem,
  output logic       is_imm,
  output logic       is_store,
  output logic       is_halt,
  output logic       alu_op
);

  // Classify the opcode into instruction groups.
  always_comb begin
    is_mem   = 1'b0;
    is_imm   = 1'b0;
    is_store = 1'b0;
    is_halt  = 1'b0;
    alu_op   = ALU_ADD;
    case (opcode)
      OP_HLT:         is_halt  = 1'b1;
      OP_STO:         is_store = 1'b1;
      OP_LD, OP_ADD:  is_mem   = 1'b1;
      OP_SUB: begin
        is_mem = 1'b1;
        alu_op = ALU_SUB;
      end
      OP_LDI, OP_ADDI: is_imm  = 1'b1;
      OP_SUBI: begin
        is_imm = 1'b1;
        alu_op = ALU_SUB;
      end
      default:        is_mem   = 1'b0;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle BIP control unit: fetch/latch/execute FSM with PC and IR,
// driving accumulator data-path selects and the data-RAM write strobe.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter logic [10:0] PC_RESET = 11'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [10:0] prog_addr_o,
  input  logic [15:0] prog_data_i,
  output logic [10:0] operand_o,
  output logic [1:0]  sela_o,
  output logic        selb_o,
  output logic        op_o,
  output logic        wracc_o,
  output logic        ram_we_o,
  output logic        halted_o
);

  state_e      state_r, state_s;
  logic [10:0] pc_r;
  logic [15:0] ir_r;
  logic        is_mem_s, is_imm_s, is_store_s, is_halt_s, alu_op_s, is_load_s;
  logic [1:0]  sela_s;
  logic        selb_s, op_s, wracc_s, ram_we_s, halted_s;

  bip_decoder u_decoder (
    .opcode   (ir_r[15:11]),
    .is_mem   (is_mem_s),
    .is_imm   (is_imm_s),
    .is_store (is_store_s),
    .is_halt  (is_halt_s),
    .alu_op   (alu_op_s)
  );

  // LD and LDI bypass the ALU; the rest of the accumulator writers use it.
  assign is_load_s = (ir_r[15:11] == OP_LD) || (ir_r[15:11] == OP_LDI);

  // State, program counter and instruction register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_FETCH;
      pc_r    <= PC_RESET;
      ir_r    <= 16'd0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_LATCH) begin
        ir_r <= prog_data_i;
        pc_r <= pc_r + 11'd1;
      end else begin
        ir_r <= ir_r;
        pc_r <= pc_r;
      end
    end
  end

  // Next-state and control decode from current state and IR.
  always_comb begin
    state_s  = state_r;
    sela_s   = SELA_RAM;
    selb_s   = 1'b0;
    op_s     = ALU_ADD;
    wracc_s  = 1'b0;
    ram_we_s = 1'b0;
    halted_s = 1'b0;
    case (state_r)
      ST_FETCH: state_s = ST_LATCH;
      ST_LATCH: state_s = ST_EXEC;
      ST_EXEC: begin
        if (is_halt_s) begin
          state_s = ST_HALT;
        end else if (is_mem_s) begin
          state_s = ST_MEMRD;
        end else if (is_store_s) begin
          state_s  = ST_FETCH;
          ram_we_s = 1'b1;
        end else if (is_imm_s) begin
          state_s = ST_FETCH;
          wracc_s = 1'b1;
          sela_s  = is_load_s ? SELA_IMM : SELA_ALU;
          selb_s  = ~is_load_s;
          op_s    = alu_op_s;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_MEMRD: begin
        state_s = ST_FETCH;
        wracc_s = 1'b1;
        sela_s  = is_load_s ? SELA_RAM : SELA_ALU;
        op_s    = alu_op_s;
      end
      ST_HALT:  halted_s = 1'b1;
      default:  state_s  = ST_FETCH;
    endcase
  end

  assign prog_addr_o = pc_r;
  assign operand_o   = ir_r[10:0];
  assign sela_o      = sela_s;
  assign selb_o      = selb_s;
  assign op_o        = op_s;
  assign wracc_o     = wracc_s;
  assign ram_we_o    = ram_we_s;
  assign halted_o    = halted_s;

endmodule
